dmem_sram_responder: RTL and testbench

- Memory-side responder for the core's data/instruction memory interface.
- Gives the initiator (EXU/LSU, IFU) a valid/ready handshaked word-addressed SRAM with separate read and write channels and configurable access latency.
- Replaces the zero-latency combinational memory path with a multi-cycle slave that the core must handshake with.
- Backing store is an internal word array mapped at BASE.

---
 rtl/dmem_sram_responder.sv | 164 ++++++++++++++++
 tb/tb_dmem_sram_responder.sv | 467 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_sram_responder.sv
// dmem_sram_responder: word-addressed SRAM slave behind valid/ready read and
// write channels. One transaction is in flight at a time. Each access waits
// LATENCY extra cycles before its response. Addresses outside
// [BASE, BASE+4*DEPTH) get DECERR and never touch the array.
module dmem_sram_responder #(
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int          DEPTH   = 4096,
  parameter int          LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int          AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_W     = 32'(DEPTH);
  localparam logic [3:0]  LAT_W       = 4'(LATENCY);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP} state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic            hit_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wdata_q;
  logic [3:0]      wstrb_q;
  logic            cur_hit;
  logic [AW-1:0]   cur_idx;
  logic [31:0]     cur_wdata;
  logic [3:0]      cur_wstrb;
  logic            rd_acc;
  logic            wr_acc;
  logic            rd_go;
  logic            wr_go;
  logic [31:0]     mem [DEPTH];

  // Offset is taken before the range compare so BASE+4*DEPTH cannot overflow.
  function automatic logic addr_hit(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (a >= BASE) && ((off >> 2) < DEPTH_W);
  endfunction

  function automatic logic [AW-1:0] addr_idx(input logic [31:0] a);
    return AW'((a - BASE) >> 2);
  endfunction

  // Address and data are only taken together, and reads win any tie.
  assign arready = (state == IDLE) && !rst;
  assign awready = (state == IDLE) && !rst && awvalid && wvalid && !arvalid;
  assign wready  = awready;
  assign rd_acc  = arvalid && arready;
  assign wr_acc  = awready;

  // Entry into a response state; with LATENCY=0 this happens straight from IDLE.
  assign rd_go = (rd_acc && (LATENCY == 0)) || ((state == RD_WAIT) && (cnt == 4'd1));
  assign wr_go = (wr_acc && (LATENCY == 0)) || ((state == WR_WAIT) && (cnt == 4'd1));

  // Current request fields: live inputs while idle, captured copies afterwards.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
    cur_hit   = hit_q;
    cur_idx   = idx_q;
    cur_wdata = wdata_q;
    cur_wstrb = wstrb_q;
    if (state == IDLE) begin
      cur_hit   = addr_hit(arvalid ? araddr : awaddr);
      cur_idx   = addr_idx(arvalid ? araddr : awaddr);
      cur_wdata = wdata;
      cur_wstrb = wstrb;
    end
  end

  // Capture request fields while idle; they freeze once a transaction starts.
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      hit_q   <= cur_hit;
      idx_q   <= cur_idx;
      wdata_q <= cur_wdata;
      wstrb_q <= cur_wstrb;
    end
  end

  // Transaction FSM with registered response channels.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      rvalid <= 1'b0;
      bvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= RESP_OKAY;
      bresp  <= RESP_OKAY;
    end else begin
      case (state)
        IDLE: begin
          if (rd_acc) begin
            cnt   <= LAT_W;
            state <= (LATENCY == 0) ? RD_RESP : RD_WAIT;
          end else if (wr_acc) begin
            cnt   <= LAT_W;
            state <= (LATENCY == 0) ? WR_RESP : WR_WAIT;
          end
        end
        RD_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RD_RESP;
        end
        RD_RESP: if (rready) state <= IDLE;
        WR_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= WR_RESP;
        end
        WR_RESP: if (bready) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (rd_go) begin
        rvalid <= 1'b1;
        rdata  <= cur_hit ? mem[cur_idx] : '0;
        rresp  <= cur_hit ? RESP_OKAY : RESP_DECERR;
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end

      if (wr_go) begin
        bvalid <= 1'b1;
        bresp  <= cur_hit ? RESP_OKAY : RESP_DECERR;
      end else if (bvalid && bready) begin
        bvalid <= 1'b0;
      end
    end
  end

  // Byte-lane write commits on the edge that enters WR_RESP.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; a reset only discards writes that have not committed yet.
    if (wr_go && cur_hit && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (cur_wstrb[i]) mem[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_sram_responder.sv
// tb_dmem_sram_responder: scoreboard bench. The driver pushes the expected
// response (from a word-array model) at each accept; a monitor pops and compares
// on each response handshake and checks timing and hold-while-stalled. Two
// extra instances cover the LATENCY=0 and LATENCY=4 builds and mid-transaction reset.
module tb_dmem_sram_responder;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 4096;
  localparam int          LAT   = 1;

  logic        clk;
  logic        rst;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic        arvalid, awvalid, wvalid;
  logic [3:0]  wstrb;
  logic        arready, awready, wready, rvalid, bvalid;
  logic [1:0]  rresp, bresp;
  bit          rready, bready;

  logic [31:0] z_araddr, z_awaddr, z_wdata, z_rdata;
  logic        z_arvalid, z_awvalid, z_wvalid, z_rready, z_bready;
  logic [3:0]  z_wstrb;
  logic        z_arready, z_awready, z_wready, z_rvalid, z_bvalid;
  logic [1:0]  z_rresp, z_bresp;

  logic        f_rst;
  logic [31:0] f_araddr, f_awaddr, f_wdata, f_rdata;
  logic        f_arvalid, f_awvalid, f_wvalid, f_rready, f_bready;
  logic [3:0]  f_wstrb;
  logic        f_arready, f_awready, f_wready, f_rvalid, f_bvalid;
  logic [1:0]  f_rresp, f_bresp;

  dmem_sram_responder #(.BASE(BASE), .DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  dmem_sram_responder #(.BASE(BASE), .DEPTH(DEPTH), .LATENCY(0)) u_lat0 (
    .clk(clk), .rst(rst),
    .araddr(z_araddr), .arvalid(z_arvalid), .arready(z_arready),
    .rdata(z_rdata), .rresp(z_rresp), .rvalid(z_rvalid), .rready(z_rready),
    .awaddr(z_awaddr), .awvalid(z_awvalid), .awready(z_awready),
    .wdata(z_wdata), .wstrb(z_wstrb), .wvalid(z_wvalid), .wready(z_wready),
    .bresp(z_bresp), .bvalid(z_bvalid), .bready(z_bready)
  );

  dmem_sram_responder #(.BASE(BASE), .DEPTH(DEPTH), .LATENCY(4)) u_lat4 (
    .clk(clk), .rst(f_rst),
    .araddr(f_araddr), .arvalid(f_arvalid), .arready(f_arready),
    .rdata(f_rdata), .rresp(f_rresp), .rvalid(f_rvalid), .rready(f_rready),
    .awaddr(f_awaddr), .awvalid(f_awvalid), .awready(f_awready),
    .wdata(f_wdata), .wstrb(f_wstrb), .wvalid(f_wvalid), .wready(f_wready),
    .bresp(f_bresp), .bvalid(f_bvalid), .bready(f_bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] data; logic [1:0] resp; int due; } rexp_t;
  typedef struct { logic [1:0] resp; int due; } bexp_t;
  rexp_t       rq[$];
  bexp_t       bq[$];
  logic [31:0] ref_mem [int];

  function automatic bit in_rng(input logic [31:0] a);
    longint la, lb;
    la = longint'({32'd0, a});
    lb = longint'({32'd0, BASE});
    return (la >= lb) && (la < lb + 4 * DEPTH);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  task automatic push_read(input logic [31:0] a, input int c);
    rexp_t e;
    if (in_rng(a)) begin
      e.data = ref_mem.exists(word_of(a)) ? ref_mem[word_of(a)] : 32'h0;
      e.resp = 2'b00;
    end else begin
      e.data = 32'h0;
      e.resp = 2'b11;
    end
    e.due = c + LAT + 1;
    rq.push_back(e);
  endtask

  task automatic push_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int c);
    bexp_t e;
    logic [31:0] w;
    if (in_rng(a)) begin
      w = ref_mem.exists(word_of(a)) ? ref_mem[word_of(a)] : 32'h0;
      for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
      ref_mem[word_of(a)] = w;
      e.resp = 2'b00;
    end else begin
      e.resp = 2'b11;
    end
    e.due = c + LAT + 1;
    bq.push_back(e);
  endtask

  // ---------------- response-side backpressure ----------------
  bit bp_mode = 0;
  bit rr_force = 1;
  bit br_force = 1;
  always @(posedge clk) begin
    #1;
    if (bp_mode) begin
      rready = ($urandom_range(0, 3) != 0);
      bready = ($urandom_range(0, 3) != 0);
    end else begin
      rready = rr_force;
      bready = br_force;
    end
  end

  // ---------------- monitor ----------------
  logic        rv_d = 0, rr_d = 0, bv_d = 0, br_d = 0;
  logic [31:0] rd_d = 0;
  logic [1:0]  rs_d = 0, bs_d = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (rvalid && !rv_d) begin
        if (rq.size() == 0) check("r_unexpected", 1, 0);
        else check("r_latency_cycle", cyc, rq[0].due);
      end
      if (rvalid && rv_d && !rr_d) begin
        check("r_hold_data", rdata, rd_d);
        check("r_hold_resp", rresp, rs_d);
      end
      if (rvalid && rready && rq.size() != 0) begin
        check("r_data", rdata, rq[0].data);
        check("r_resp", rresp, rq[0].resp);
        void'(rq.pop_front());
      end
      if (bvalid && !bv_d) begin
        if (bq.size() == 0) check("b_unexpected", 1, 0);
        else check("b_latency_cycle", cyc, bq[0].due);
      end
      if (bvalid && bv_d && !br_d) check("b_hold_resp", bresp, bs_d);
      if (bvalid && bready && bq.size() != 0) begin
        check("b_resp", bresp, bq[0].resp);
        void'(bq.pop_front());
      end
    end
    rv_d = rvalid; rr_d = rready; rd_d = rdata; rs_d = rresp;
    bv_d = bvalid; br_d = bready; bs_d = bresp;
  end

  // ---------------- driver helpers (enter and leave at posedge+1) ----------------
  task automatic wait_accept(input bit is_rd, output int c);
    bit got;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (is_rd ? (arvalid && arready) : (awvalid && wvalid && awready && wready)) got = 1;
    end
    c = cyc;
    check(is_rd ? "ar_accept_timeout" : "aw_accept_timeout", got, 1);
  endtask

  task automatic wait_rdone();
    bit got;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (rvalid && rready) got = 1;
    end
    check("r_done_timeout", got, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_bdone();
    bit got;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (bvalid && bready) got = 1;
    end
    check("b_done_timeout", got, 1);
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [31:0] a);
    int c;
    araddr = a; arvalid = 1;
    wait_accept(1, c);
    push_read(a, c);
    @(posedge clk); #1;
    arvalid = 0; araddr = $urandom;
    wait_rdone();
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int c;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
    wait_accept(0, c);
    push_write(a, d, s, c);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; awaddr = $urandom; wdata = $urandom;
    wait_bdone();
  endtask

  task automatic f_issue_write(input logic [31:0] a, input logic [31:0] d);
    bit got;
    got = 0;
    f_awaddr = a; f_wdata = d; f_wstrb = 4'hF; f_awvalid = 1; f_wvalid = 1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (f_awready) got = 1;
    end
    check("f_aw_accept_timeout", got, 1);
    @(posedge clk); #1;
    f_awvalid = 0; f_wvalid = 0;
  endtask

  task automatic f_wait_bvalid();
    bit got;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (f_bvalid) got = 1;
    end
    check("f_bvalid_timeout", got, 1);
    @(posedge clk); #1;
  endtask

  task automatic f_read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    bit got;
    int c;
    got = 0;
    f_araddr = a; f_arvalid = 1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (f_arready) got = 1;
    end
    c = cyc;
    check("f_ar_accept_timeout", got, 1);
    @(posedge clk); #1;
    f_arvalid = 0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (f_rvalid) got = 1;
    end
    check("f_rvalid_timeout", got, 1);
    check("f_rvalid_cycle", cyc, c + 5);
    check(name, f_rdata, exp);
    @(posedge clk); #1;
  endtask

  logic [31:0] pool [8];
  logic [31:0] oor  [4];

  initial begin
    bit seen;
    int c;
    araddr = 0; arvalid = 0; awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0;
    z_araddr = 0; z_arvalid = 0; z_awaddr = 0; z_awvalid = 0; z_wdata = 0; z_wstrb = 0;
    z_wvalid = 0; z_rready = 1; z_bready = 1;
    f_araddr = 0; f_arvalid = 0; f_awaddr = 0; f_awvalid = 0; f_wdata = 0; f_wstrb = 0;
    f_wvalid = 0; f_rready = 1; f_bready = 1;
    pool = '{BASE, BASE + 4, BASE + 16, BASE + 20, BASE + 400,
             BASE + 4 * 2047, BASE + 4 * 4094, BASE + 4 * 4095};
    oor  = '{32'h7FFF_FFFC, BASE + 4 * DEPTH, 32'hFFFF_FFFC, 32'h0000_0000};

    // Reset with a write request pending: nothing may be accepted or valid.
    rst = 1; f_rst = 1; awvalid = 1; wvalid = 1; awaddr = BASE; wdata = 32'h0BAD_0BAD; wstrb = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_arready", arready, 0);
    check("rst_awready", awready, 0);
    check("rst_wready", wready, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_rresp", rresp, 0);
    check("rst_bresp", bresp, 0);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; rst = 0; f_rst = 0;
    @(negedge clk);
    check("idle_arready", arready, 1);
    @(posedge clk); #1;

    // Give every pool word a known value.
    foreach (pool[i]) do_write(pool[i], $urandom, 4'hF);

    // Full write then read back.
    do_write(BASE + 16, 32'hDEAD_BEEF, 4'hF);
    do_read(BASE + 16);
    // Single-lane write; low address bits are ignored.
    do_write(BASE + 16, 32'h0000_00AA, 4'b0001);
    do_read(BASE + 16);
    do_read(BASE + 19);
    check("model_partial", ref_mem[4], 32'hDEAD_BEAA);
    // Strobe zero: OKAY and no change.
    do_write(BASE + 16, 32'h5555_5555, 4'b0000);
    do_read(BASE + 16);

    // Read and write requested together: read wins, write follows.
    araddr = BASE + 16; arvalid = 1;
    awaddr = BASE + 16; wdata = 32'h1111_1111; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    wait_accept(1, c);
    check("prio_awready", awready, 0);
    check("prio_wready", wready, 0);
    push_read(BASE + 16, c);
    @(posedge clk); #1;
    arvalid = 0;
    wait_rdone();
    wait_accept(0, c);
    push_write(BASE + 16, 32'h1111_1111, 4'hF, c);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    wait_bdone();
    do_read(BASE + 16);

    // Read response backpressure for 5 cycles.
    rr_force = 0;
    @(posedge clk); #1;
    araddr = BASE + 16; arvalid = 1;
    wait_accept(1, c);
    push_read(BASE + 16, c);
    @(posedge clk); #1;
    arvalid = 0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (rvalid) seen = 1;
    end
    check("bp_rvalid_timeout", seen, 1);
    for (int i = 0; i < 5; i++) begin
      check("bp_rvalid_held", rvalid, 1);
      check("bp_arready_low", arready, 0);
      @(negedge clk);
    end
    rr_force = 1;
    wait_rdone();
    @(negedge clk);
    check("bp_arready_after", arready, 1);
    @(posedge clk); #1;

    // Out-of-range accesses and an untouched neighbour.
    do_read(32'h7FFF_FFFC);
    do_write(BASE + 4 * DEPTH, 32'hCAFE_F00D, 4'hF);
    do_read(BASE);

    // LATENCY=0 instance: responses one cycle after accept.
    z_awaddr = BASE + 32; z_wdata = 32'h1234_5678; z_wstrb = 4'hF; z_awvalid = 1; z_wvalid = 1;
    @(negedge clk);
    check("z_awready", z_awready, 1);
    @(posedge clk); #1;
    z_awvalid = 0; z_wvalid = 0;
    @(negedge clk);
    check("z_bvalid", z_bvalid, 1);
    check("z_bresp", z_bresp, 0);
    @(posedge clk); #1;
    z_araddr = BASE + 32; z_arvalid = 1;
    @(negedge clk);
    check("z_arready", z_arready, 1);
    check("z_rvalid_before", z_rvalid, 0);
    @(posedge clk); #1;
    z_arvalid = 0;
    @(negedge clk);
    check("z_rvalid", z_rvalid, 1);
    check("z_rdata", z_rdata, 32'h1234_5678);
    @(posedge clk); #1;

    // LATENCY=4 instance: a write reset during WR_WAIT is discarded.
    f_issue_write(BASE + 64, 32'hAAAA_5555);
    f_wait_bvalid();
    f_issue_write(BASE + 64, 32'h0000_0000);
    @(posedge clk); #1;
    f_rst = 1;
    @(negedge clk);
    check("f_rst_arready", f_arready, 0);
    check("f_rst_awready", f_awready, 0);
    @(posedge clk); #1;
    f_rst = 0;
    @(negedge clk);
    check("f_wr_rst_bvalid", f_bvalid, 0);
    @(posedge clk); #1;
    f_read_check("f_discarded_write", BASE + 64, 32'hAAAA_5555);

    // Reset during RD_WAIT: idle two cycles later with no response.
    f_araddr = BASE + 64; f_arvalid = 1;
    @(negedge clk);
    check("f_arready_pre", f_arready, 1);
    @(posedge clk); #1;
    f_arvalid = 0;
    @(posedge clk); #1;
    f_rst = 1;
    @(negedge clk);
    check("f_rd_rst_rvalid", f_rvalid, 0);
    @(posedge clk); #1;
    f_rst = 0;
    @(negedge clk);
    check("f_after_rst_rvalid", f_rvalid, 0);
    check("f_after_rst_arready", f_arready, 1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (f_rvalid) seen = 1;
    end
    check("f_no_stale_rvalid", seen, 0);
    @(posedge clk); #1;

    // A write that reached WR_RESP survives a reset before bready.
    f_bready = 0;
    f_issue_write(BASE + 68, 32'h5A5A_5A5A);
    f_wait_bvalid();
    f_rst = 1;
    @(posedge clk); #1;
    f_rst = 0; f_bready = 1;
    f_read_check("f_committed_write", BASE + 68, 32'h5A5A_5A5A);

    // Randomized traffic with random response backpressure.
    bp_mode = 1;
    for (int n = 0; n < 150; n++) begin
      int r;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      if (r < 4) begin
        a = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
        do_read(a);
      end else if (r < 8) begin
        a = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
        do_write(a, $urandom, 4'($urandom_range(0, 15)));
      end else if (r == 8) begin
        do_read(oor[$urandom_range(0, 3)]);
      end else begin
        do_write(oor[$urandom_range(0, 3)], $urandom, 4'hF);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    bp_mode = 0;
    repeat (4) @(posedge clk);
    #1;
    check("rq_drained", rq.size(), 0);
    check("bq_drained", bq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
